// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_pkg : opcodes and control-word layout for the pipeline controller
// Revision      : 1.0
// ============================================================================
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int CW_VALID    = 0;
  localparam int CW_REGWRITE = 1;
  localparam int CW_REGDST   = 2;
  localparam int CW_ALUOP    = 3;
  localparam int CW_MEMREAD  = 4;
  localparam int CW_MEMWRITE = 5;
  localparam int CW_MEMTOREG = 6;
  localparam int CW_BRANCH   = 7;
  localparam int CW_W        = 8;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_unit_decode.sv
`default_nettype none
// ============================================================================
// ctrl_decode : combinational opcode -> control word (valid bit left clear)
// Revision    : 1.0
// ============================================================================
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic             id_valid_i,
  input  logic [OPW-1:0]   opcode_i,
  output logic [CW_W-1:0]  ctrl_o,
  output logic             illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPW'(OP_LW): begin
        ctrl_o[CW_REGWRITE] = 1'b1;
        ctrl_o[CW_MEMREAD]  = 1'b1;
        ctrl_o[CW_MEMTOREG] = 1'b1;
      end
      OPW'(OP_SW): begin
        ctrl_o[CW_MEMWRITE] = 1'b1;
      end
      OPW'(OP_RTYPE): begin
        ctrl_o[CW_REGWRITE] = 1'b1;
        ctrl_o[CW_REGDST]   = 1'b1;
      end
      OPW'(OP_XORI): begin
        ctrl_o[CW_REGWRITE] = 1'b1;
        ctrl_o[CW_ALUOP]    = 1'b1;
      end
      OPW'(OP_J): begin
        ctrl_o[CW_BRANCH] = 1'b1;
      end
      default: begin
        illegal_o = id_valid_i;
      end
    endcase
  end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_unit : ID decode, load-use bubbles, freeze/flush and a control
//                  pipeline of NSTAGES stages with a bubble counter
// Revision       : 1.0
// ============================================================================
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int RW       = 5,
  parameter int NSTAGES  = 4,
  parameter int LU_DEPTH = 2,
  parameter int CNTW     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [OPW-1:0]          id_opcode,
  input  logic [RW-1:0]           id_rs,
  input  logic [RW-1:0]           id_rt,
  input  logic [RW-1:0]           id_rd,
  input  logic                    freeze,
  input  logic                    flush,
  output logic [NSTAGES*CW_W-1:0] stage_ctrl,
  output logic [NSTAGES*RW-1:0]   stage_dest,
  output logic                    id_hold,
  output logic                    illegal_op,
  output logic [CNTW-1:0]         bubble_cnt
);

  logic [CW_W-1:0]    w_dec_ctrl;
  logic               w_dec_illegal;
  logic [RW-1:0]      w_id_dest;
  logic [NSTAGES-1:0] w_haz_stage;
  logic               w_hazard;
  logic               w_bubble;
  logic               w_count;
  logic [CW_W-1:0]    w_s0_ctrl;
  logic [RW-1:0]      w_s0_dest;
  logic [CNTW-1:0]    cnt_q;
  logic [CNTW-1:0]    cnt_d;

  ctrl_decode #(
    .OPW (OPW)
  ) u_decode (
    .id_valid_i (id_valid),
    .opcode_i   (id_opcode),
    .ctrl_o     (w_dec_ctrl),
    .illegal_o  (w_dec_illegal)
  );

  always_comb begin
    w_id_dest = w_dec_ctrl[CW_REGDST] ? id_rd : id_rt;
    if (!w_dec_ctrl[CW_REGWRITE]) begin
      w_id_dest = '0;
    end
  end

  assign w_hazard   = id_valid & (|w_haz_stage);
  assign id_hold    = w_hazard | freeze;
  assign illegal_op = w_dec_illegal;

  // An illegal opcode is a bubble but is not counted as a hazard/flush bubble.
  assign w_bubble = flush | w_hazard | ~id_valid | w_dec_illegal;
  assign w_count  = id_valid & (w_hazard | flush);

  always_comb begin
    w_s0_ctrl = '0;
    w_s0_dest = '0;
    if (!w_bubble) begin
      w_s0_ctrl           = w_dec_ctrl;
      w_s0_ctrl[CW_VALID] = 1'b1;
      w_s0_dest           = w_id_dest;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NSTAGES; k++) begin : g_stage
      logic [CW_W-1:0] ctrl_q;
      logic [CW_W-1:0] ctrl_d;
      logic [RW-1:0]   dest_q;
      logic [RW-1:0]   dest_d;

      if (k == 0) begin : g_load
        assign ctrl_d = w_s0_ctrl;
        assign dest_d = w_s0_dest;
      end else begin : g_shift
        assign ctrl_d = g_stage[k-1].ctrl_q;
        assign dest_d = g_stage[k-1].dest_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctrl_q <= '0;
          dest_q <= '0;
        end else if (!freeze) begin
          ctrl_q <= ctrl_d;
          dest_q <= dest_d;
        end
      end

      assign stage_ctrl[k*CW_W +: CW_W] = ctrl_q;
      assign stage_dest[k*RW +: RW]     = dest_q;

      // Only the leading stages can still hold a load whose data is not ready.
      if (k < LU_DEPTH) begin : g_lu
        assign w_haz_stage[k] = ctrl_q[CW_VALID] & ctrl_q[CW_MEMREAD] &
                                (dest_q != '0) &
                                ((dest_q == id_rs) | (dest_q == id_rt));
      end else begin : g_no_lu
        assign w_haz_stage[k] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (w_count && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule : pipe_ctrl_unit
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_pipe_ctrl_unit : table-driven decode vectors plus pipeline sequences
// Revision          : 1.0
// ============================================================================
module tb_pipe_ctrl_unit;

  localparam int OPW = 6;
  localparam int RW  = 5;
  localparam int NS  = 4;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [5:0]    id_opcode;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic [4:0]    id_rd;
  logic          freeze;
  logic          flush;
  logic [31:0]   stage_ctrl;
  logic [19:0]   stage_dest;
  logic          id_hold;
  logic          illegal_op;
  logic [15:0]   bubble_cnt;
  logic [31:0]   s_stage_ctrl;
  logic [19:0]   s_stage_dest;
  logic          s_id_hold;
  logic          s_illegal_op;
  logic [1:0]    s_bubble_cnt;

  int n_pass;
  int n_total;

  pipe_ctrl_unit #(.OPW(OPW), .RW(RW), .NSTAGES(NS), .LU_DEPTH(2), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .freeze(freeze), .flush(flush),
    .stage_ctrl(stage_ctrl), .stage_dest(stage_dest), .id_hold(id_hold),
    .illegal_op(illegal_op), .bubble_cnt(bubble_cnt)
  );

  pipe_ctrl_unit #(.OPW(OPW), .RW(RW), .NSTAGES(NS), .LU_DEPTH(2), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .freeze(freeze), .flush(flush),
    .stage_ctrl(s_stage_ctrl), .stage_dest(s_stage_dest), .id_hold(s_id_hold),
    .illegal_op(s_illegal_op), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [7:0] exp_ctrl;
    logic [4:0] exp_dest;
    logic       exp_illegal;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    freeze = 1'b0;
    flush  = 1'b0;
    rst_n  = 1'b0;
    #2;
    rst_n  = 1'b1;
  endtask

  function automatic logic [7:0] sc(input int k);
    logic [31:0] t;
    t = stage_ctrl >> (8 * k);
    return t[7:0];
  endfunction

  function automatic logic [4:0] sd(input int k);
    logic [19:0] t;
    t = stage_dest >> (5 * k);
    return t[4:0];
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    freeze  = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);

    //                valid op          rs     rt      rd      ctrl   dest   ill
    vecs[0] = '{1'b1, 6'b100011, 5'd3, 5'd1,  5'd9,  8'h53, 5'd1,  1'b0};
    vecs[1] = '{1'b1, 6'b101011, 5'd4, 5'd5,  5'd6,  8'h21, 5'd0,  1'b0};
    vecs[2] = '{1'b1, 6'b000000, 5'd7, 5'd8,  5'd9,  8'h07, 5'd9,  1'b0};
    vecs[3] = '{1'b1, 6'b001110, 5'd1, 5'd10, 5'd11, 8'h0B, 5'd10, 1'b0};
    vecs[4] = '{1'b1, 6'b000010, 5'd2, 5'd3,  5'd4,  8'h81, 5'd0,  1'b0};
    vecs[5] = '{1'b1, 6'b111111, 5'd2, 5'd3,  5'd4,  8'h00, 5'd0,  1'b1};
    vecs[6] = '{1'b0, 6'b100011, 5'd3, 5'd1,  5'd9,  8'h00, 5'd0,  1'b0};
    vecs[7] = '{1'b0, 6'b111111, 5'd3, 5'd1,  5'd9,  8'h00, 5'd0,  1'b0};
    vecs[8] = '{1'b1, 6'b000000, 5'd7, 5'd8,  5'd0,  8'h07, 5'd0,  1'b0};

    do_reset();
    #1;
    chk("reset_ctrl", stage_ctrl, 32'h0);
    chk("reset_dest", {12'h0, stage_dest}, 32'h0);
    chk("reset_cnt", {16'h0, bubble_cnt}, 32'h0);

    // Single-instruction decode table.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      drive(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_illegal", i), {31'h0, illegal_op}, {31'h0, vecs[i].exp_illegal});
      tick();
      chk($sformatf("v%0d_s0ctrl", i), {24'h0, sc(0)}, {24'h0, vecs[i].exp_ctrl});
      chk($sformatf("v%0d_s0dest", i), {27'h0, sd(0)}, {27'h0, vecs[i].exp_dest});
      chk($sformatf("v%0d_cnt", i), {16'h0, bubble_cnt}, 32'h0);
    end

    // lw travels to stage 3 after 4 clocks.
    do_reset();
    drive(1'b1, 6'b100011, 5'd3, 5'd1, 5'd9);
    tick();
    drive(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();
    chk("lw_s3ctrl", stage_ctrl, 32'h5300_0000);
    chk("lw_s3dest", {27'h0, sd(3)}, 32'd1);

    // Load-use: two bubbles, then the dependent add enters.
    do_reset();
    drive(1'b1, 6'b100011, 5'd3, 5'd2, 5'd0);
    tick();
    drive(1'b1, 6'b000000, 5'd2, 5'd8, 5'd9);
    #1;
    chk("lu_hold0", {31'h0, id_hold}, 32'd1);
    tick();
    chk("lu_b1_s0", {24'h0, sc(0)}, 32'h0);
    chk("lu_b1_cnt", {16'h0, bubble_cnt}, 32'd1);
    chk("lu_hold1", {31'h0, id_hold}, 32'd1);
    tick();
    chk("lu_b2_s0", {24'h0, sc(0)}, 32'h0);
    chk("lu_b2_cnt", {16'h0, bubble_cnt}, 32'd2);
    chk("lu_hold2", {31'h0, id_hold}, 32'd0);
    tick();
    chk("lu_add_s0", {24'h0, sc(0)}, 32'h07);
    chk("lu_add_dest", {27'h0, sd(0)}, 32'd9);
    chk("lu_lw_s3", {24'h0, sc(3)}, 32'h53);
    chk("lu_cnt_end", {16'h0, bubble_cnt}, 32'd2);

    // A load to r0 never creates a hazard.
    do_reset();
    drive(1'b1, 6'b100011, 5'd3, 5'd0, 5'd0);
    tick();
    drive(1'b1, 6'b000000, 5'd0, 5'd0, 5'd9);
    #1;
    chk("r0_nohold", {31'h0, id_hold}, 32'd0);
    tick();
    chk("r0_s0", {24'h0, sc(0)}, 32'h07);

    // Flush bubble, then flush together with freeze changes nothing.
    do_reset();
    drive(1'b1, 6'b000000, 5'd4, 5'd5, 5'd9);
    tick();
    drive(1'b1, 6'b001110, 5'd1, 5'd10, 5'd0);
    flush = 1'b1;
    tick();
    chk("fl_s0", {24'h0, sc(0)}, 32'h0);
    chk("fl_s1", {24'h0, sc(1)}, 32'h07);
    chk("fl_cnt", {16'h0, bubble_cnt}, 32'd1);
    freeze = 1'b1;
    #1;
    chk("flfz_hold", {31'h0, id_hold}, 32'd1);
    tick();
    chk("flfz_ctrl", stage_ctrl, 32'h0000_0700);
    chk("flfz_dest", {12'h0, stage_dest}, {12'h0, 20'h0_0120});
    chk("flfz_cnt", {16'h0, bubble_cnt}, 32'd1);

    // Asynchronous reset between edges clears everything at once.
    flush  = 1'b0;
    freeze = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", stage_ctrl, 32'h0);
    chk("arst_dest", {12'h0, stage_dest}, 32'h0);
    chk("arst_cnt", {16'h0, bubble_cnt}, 32'h0);
    #1;
    rst_n = 1'b1;

    // Freeze with a full pipeline, then release.
    do_reset();
    drive(1'b1, 6'b100011, 5'd3, 5'd1, 5'd0);
    tick();
    drive(1'b1, 6'b000000, 5'd4, 5'd5, 5'd6);
    tick();
    drive(1'b1, 6'b001110, 5'd7, 5'd8, 5'd0);
    tick();
    drive(1'b1, 6'b000010, 5'd0, 5'd0, 5'd0);
    tick();
    chk("fz_fill_ctrl", stage_ctrl, 32'h5307_0B81);
    chk("fz_fill_dest", {12'h0, stage_dest}, {12'h0, 5'd1, 5'd6, 5'd8, 5'd0});
    drive(1'b1, 6'b101011, 5'd9, 5'd9, 5'd9);
    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("fz%0d_ctrl", c), stage_ctrl, 32'h5307_0B81);
      chk($sformatf("fz%0d_dest", c), {12'h0, stage_dest}, {12'h0, 5'd1, 5'd6, 5'd8, 5'd0});
    end
    freeze = 1'b0;
    drive(1'b0, 6'b0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("fz_rel_ctrl", stage_ctrl, 32'h070B_8100);
    chk("fz_rel_dest", {12'h0, stage_dest}, {12'h0, 5'd6, 5'd8, 5'd0, 5'd0});

    // Repeated load-use pairs: the 2-bit counter saturates at 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b100011, 5'd3, 5'd2, 5'd0);
      tick();
      drive(1'b1, 6'b000000, 5'd2, 5'd8, 5'd9);
      tick(); tick(); tick();
      chk($sformatf("sat%0d_main", i), {16'h0, bubble_cnt}, 32'(2 * (i + 1)));
      chk($sformatf("sat%0d_cnt2", i), {30'h0, s_bubble_cnt},
          (2 * (i + 1) > 3) ? 32'd3 : 32'(2 * (i + 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pipe_ctrl_unit
`default_nettype wire
